mem_bus_ctrl: RTL and testbench

//  Parametrised memory-bus controller between the CPU (mem_cmd/mem_addr/write_data/read_data) and
//  on-chip RAM plus NUM_IO memory-mapped I/O channels (switch inputs, LED outputs).

---
 rtl/mem_bus_ctrl_pkg.sv | 18 +
 rtl/mem_bus_ctrl_ram.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared encodings for the CPU memory bus controller: command codes,
// controller FSM states and address-decode regions.
package mem_bus_pkg;

    localparam logic [1:0] MREAD  = 2'd1;
    localparam logic [1:0] MNONE  = 2'd2;
    localparam logic [1:0] MWRITE = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

    typedef enum logic [1:0] {REG_RAM, REG_IO, REG_UNMAPPED} region_e;

    // Only MREAD and MWRITE start a transaction; MNONE and code 0 are idle.
    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_ram.sv
// Single-port synchronous RAM with registered read data; contents are
// never reset.
module mem_bus_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RAM_AW = 8
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [RAM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**RAM_AW];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory-bus controller: decodes RAM / memory-mapped I/O, sequences each
// access through IDLE -> ACCESS -> ACK and returns registered read data.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       ADDR_W  = 9,
    parameter int unsigned       RAM_AW  = 8,
    parameter int unsigned       RAM_LAT = 1,
    parameter int unsigned       NUM_IO  = 2,
    parameter logic [ADDR_W-1:0] IO_BASE = 9'h100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mem_cmd,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic [DATA_W-1:0]        read_data,
    output logic                     mem_ready,
    input  logic [NUM_IO*DATA_W-1:0] io_in,
    output logic [NUM_IO*DATA_W-1:0] io_out,
    output logic                     bus_err
);

    localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam int unsigned CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_e                         state_q;
    region_e                        region_q, region_d;
    logic [IDX_W-1:0]               iok_q, iok_d;
    logic                           wr_q;
    logic [RAM_AW-1:0]              idx_q;
    logic [DATA_W-1:0]              wdata_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [DATA_W-1:0]              io_cap_q;
    logic [DATA_W-1:0]              read_data_q;
    logic                           mem_ready_q;
    logic                           bus_err_q;
    logic [NUM_IO-1:0][DATA_W-1:0]  io_out_q;
    logic [NUM_IO-1:0][DATA_W-1:0]  io_sync1_q, io_sync2_q;

    logic                           ram_en, ram_we;
    logic [DATA_W-1:0]              ram_rdata;

    // Zero-extending both sides makes IO_BASE+k that overflows ADDR_W never match.
    always_comb begin
        region_d = REG_UNMAPPED;
        iok_d    = '0;
        if (!mem_addr[ADDR_W-1]) begin
            region_d = REG_RAM;
        end else begin
            for (int unsigned k = 0; k < NUM_IO; k++) begin
                if (32'(mem_addr) == 32'(IO_BASE) + k) begin
                    region_d = REG_IO;
                    iok_d    = IDX_W'(k);
                end
            end
        end
    end

    // RAM op fires only in the first ACCESS cycle; a reset on that edge cancels the write.
    assign ram_en = !reset && (state_q == ACCESS) && (region_q == REG_RAM) && (cnt_q == '0);
    assign ram_we = ram_en && wr_q;

    mem_bus_ram #(
        .DATA_W (DATA_W),
        .RAM_AW (RAM_AW)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            region_q    <= REG_UNMAPPED;
            iok_q       <= '0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            io_cap_q    <= '0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            io_out_q    <= '0;
            io_sync1_q  <= '0;
            io_sync2_q  <= '0;
        end else begin
            io_sync1_q  <= io_in;
            io_sync2_q  <= io_sync1_q;
            mem_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_access(mem_cmd)) begin
                        wr_q     <= (mem_cmd == MWRITE);
                        idx_q    <= mem_addr[RAM_AW-1:0];
                        wdata_q  <= write_data;
                        region_q <= region_d;
                        iok_q    <= iok_d;
                        cnt_q    <= '0;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    case (region_q)
                        REG_RAM: begin
                            if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ACK;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        REG_IO: begin
                            if (wr_q) begin
                                io_out_q[iok_q] <= wdata_q;
                            end else begin
                                io_cap_q <= io_sync2_q[iok_q];
                            end
                            state_q <= ACK;
                        end
                        default: begin
                            bus_err_q <= 1'b1;
                            io_cap_q  <= '0;
                            state_q   <= ACK;
                        end
                    endcase
                end
                ACK: begin
                    mem_ready_q <= 1'b1;
                    if (wr_q) begin
                        read_data_q <= '0;
                    end else if (region_q == REG_RAM) begin
                        read_data_q <= ram_rdata;
                    end else if (region_q == REG_IO) begin
                        read_data_q <= io_cap_q;
                    end else begin
                        read_data_q <= '0;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: RAM_LAT=1 and RAM_LAT=3 instances,
// expected acks queued at drive time and matched when mem_ready strobes.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  c0 = MNONE, c3 = MNONE;
    logic [8:0]  a0 = '0, a3 = '0;
    logic [15:0] w0 = '0, w3 = '0;
    logic [15:0] rd0, rd3;
    logic        rdy0, rdy3, err0, err3;
    logic [31:0] io_in = '0;
    logic [31:0] io_out0, io_out3;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned acks0 = 0;
    int unsigned acks3 = 0;
    exp_t        q0[$];
    exp_t        q3[$];

    mem_bus_ctrl #(.RAM_LAT(1)) dut (
        .clk(clk), .reset(reset), .mem_cmd(c0), .mem_addr(a0), .write_data(w0),
        .read_data(rd0), .mem_ready(rdy0), .io_in(io_in), .io_out(io_out0), .bus_err(err0)
    );

    mem_bus_ctrl #(.RAM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .mem_cmd(c3), .mem_addr(a3), .write_data(w3),
        .read_data(rd3), .mem_ready(rdy3), .io_in(io_in), .io_out(io_out3), .bus_err(err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rdy0) begin
            acks0++;
            if (q0.size() == 0) begin
                check("unexpected_ack", 32'(rdy0), 32'd0);
            end else begin
                e = q0.pop_front();
                check("read_data", 32'(rd0), 32'(e.rd));
                check("ack_cycle", cyc, e.cyc);
                check("bus_err", 32'(err0), 32'(e.err));
            end
        end
        if (rdy3) begin
            acks3++;
            if (q3.size() == 0) begin
                check("unexpected_ack_lat3", 32'(rdy3), 32'd0);
            end else begin
                e = q3.pop_front();
                check("read_data_lat3", 32'(rd3), 32'(e.rd));
                check("ack_cycle_lat3", cyc, e.cyc);
            end
        end
    end

    task automatic run_txn(input bit sel, input logic [1:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wd, input logic [15:0] rd, input logic err,
                           input int unsigned lat);
        exp_t        e;
        int unsigned n;
        @(negedge clk);
        e.rd  = rd;
        e.err = err;
        e.cyc = cyc + 1 + lat;
        if (sel) begin
            q3.push_back(e);
            c3 = cmd; a3 = addr; w3 = wd;
        end else begin
            q0.push_back(e);
            c0 = cmd; a0 = addr; w0 = wd;
        end
        n = 0;
        @(negedge clk);
        while (!(sel ? rdy3 : rdy0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_timeout", 32'(n < 20), 32'd1);
        if (sel) c3 = MNONE;
        else c0 = MNONE;
    endtask

    vec_t        vt[14];
    int unsigned base;
    int unsigned n;
    int unsigned p;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{MWRITE, 9'h005, 16'hBEEF, 16'h0000, 1'b0};
        vt[1]  = '{MREAD,  9'h005, 16'h0000, 16'hBEEF, 1'b0};
        vt[2]  = '{MWRITE, 9'h0AA, 16'h1234, 16'h0000, 1'b0};
        vt[3]  = '{MREAD,  9'h0AA, 16'h0000, 16'h1234, 1'b0};
        vt[4]  = '{MWRITE, 9'h007, 16'h5555, 16'h0000, 1'b0};
        vt[5]  = '{MREAD,  9'h007, 16'h0000, 16'h5555, 1'b0};
        vt[6]  = '{MWRITE, 9'h101, 16'h03FF, 16'h0000, 1'b0};
        vt[7]  = '{MREAD,  9'h101, 16'h0000, 16'hA5A5, 1'b0};
        vt[8]  = '{MREAD,  9'h100, 16'h0000, 16'h0123, 1'b0};
        vt[9]  = '{MREAD,  9'h1F0, 16'h0000, 16'h0000, 1'b1};
        vt[10] = '{MREAD,  9'h005, 16'h0000, 16'hBEEF, 1'b1};
        vt[11] = '{MWRITE, 9'h102, 16'hDEAD, 16'h0000, 1'b1};
        vt[12] = '{MWRITE, 9'h0FF, 16'h7777, 16'h0000, 1'b1};
        vt[13] = '{MREAD,  9'h0FF, 16'h0000, 16'h7777, 1'b1};

        io_in = 32'hA5A5_0123;
        repeat (4) @(negedge clk);
        check("rst_read_data", 32'(rd0), 32'd0);
        check("rst_mem_ready", 32'(rdy0), 32'd0);
        check("rst_io_out", io_out0, 32'd0);
        check("rst_bus_err", 32'(err0), 32'd0);
        reset = 1'b0;

        run_txn(1'b1, MWRITE, 9'h010, 16'hC0DE, 16'h0000, 1'b0, 4);
        run_txn(1'b1, MREAD,  9'h010, 16'h0000, 16'hC0DE, 1'b0, 4);

        for (int i = 0; i < 14; i++) begin
            run_txn(1'b0, vt[i].cmd, vt[i].addr, vt[i].wd, vt[i].rd, vt[i].err, 2);
        end
        @(negedge clk);
        check("io_out_after_writes", io_out0, 32'h03FF_0000);
        check("bus_err_sticky", 32'(err0), 32'd1);

        // Reset lands while the write of 9'h007 is in ACCESS.
        @(negedge clk);
        c0 = MWRITE; a0 = 9'h007; w0 = 16'h1111;
        @(negedge clk);
        reset = 1'b1;
        c0 = MNONE;
        repeat (2) @(negedge clk);
        check("midrst_mem_ready", 32'(rdy0), 32'd0);
        check("midrst_read_data", 32'(rd0), 32'd0);
        check("midrst_io_out", io_out0, 32'd0);
        check("midrst_bus_err", 32'(err0), 32'd0);
        reset = 1'b0;
        run_txn(1'b0, MREAD, 9'h007, 16'h0000, 16'h5555, 1'b0, 2);

        // MREAD held across acks: one new transaction every 3 cycles.
        @(negedge clk);
        base = acks0;
        p = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{rd: 16'hBEEF, err: 1'b0, cyc: p + 2 + 3 * k});
        end
        c0 = MREAD; a0 = 9'h005;
        n = 0;
        while (acks0 < base + 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_timeout", 32'(n < 40), 32'd1);
        c0 = 2'b00;
        base = acks0;
        repeat (6) @(negedge clk);
        c0 = MNONE;
        repeat (6) @(negedge clk);
        check("idle_no_ack", acks0, base);
        check("sb_empty", q0.size(), 32'd0);
        check("sb3_empty", q3.size(), 32'd0);
        check("acks3_count", acks3, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
